alu: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shifter.sv | 33 +++
 rtl/alu.sv | 72 +++++++
 tb/tb_alu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: operand width, select codes
// and a bit-reversal helper used by the shifter.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
        logic [XLEN-1:0] reversed;
        reversed = '0;
        for (int i = 0; i < XLEN; i++) begin
            reversed[i] = value[XLEN-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter. Left shifts reuse the right-shift network
// by bit-reversing the data on the way in and out.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  logic            dir,
    input  logic            arith,
    output logic [XLEN-1:0] result
);

    logic            fill;
    logic [XLEN-1:0] stage0;
    logic [XLEN-1:0] stage1;
    logic [XLEN-1:0] stage2;
    logic [XLEN-1:0] stage3;
    logic [XLEN-1:0] stage4;
    logic [XLEN-1:0] stage5;

    // dir=1 selects a left shift, which never sign-fills
    assign fill   = arith & ~dir & data[XLEN-1];
    assign stage0 = dir ? bit_reverse(data) : data;

    assign stage1 = shamt[0] ? {{1{fill}},  stage0[XLEN-1:1]}  : stage0;
    assign stage2 = shamt[1] ? {{2{fill}},  stage1[XLEN-1:2]}  : stage1;
    assign stage3 = shamt[2] ? {{4{fill}},  stage2[XLEN-1:4]}  : stage2;
    assign stage4 = shamt[3] ? {{8{fill}},  stage3[XLEN-1:8]}  : stage3;
    assign stage5 = shamt[4] ? {{16{fill}}, stage4[XLEN-1:16]} : stage4;

    assign result = dir ? bit_reverse(stage5) : stage5;

endmodule

// File: rtl/alu.sv
// RV32I ALU with a registered result and registered zero / branch-compare flags.
// The compare flags track A and B every cycle, independent of the selected operation.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      sel,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            lt_signed,
    output logic            lt_unsigned
);

    logic            is_sub;
    logic [XLEN-1:0] adder_b;
    logic [XLEN-1:0] adder_sum;
    logic [XLEN-1:0] shift_result;
    logic            lt_signed_next;
    logic            lt_unsigned_next;
    logic [XLEN-1:0] result_next;

    // One shared adder: subtraction is A + ~B + 1
    assign is_sub    = (sel == ALU_SUB);
    assign adder_b   = is_sub ? ~B : B;
    assign adder_sum = A + adder_b + {{(XLEN-1){1'b0}}, is_sub};

    assign lt_signed_next   = $signed(A) < $signed(B);
    assign lt_unsigned_next = A < B;

    alu_shifter u_shifter (
        .data   (A),
        .shamt  (B[4:0]),
        .dir    (sel == ALU_SLL),
        .arith  (sel == ALU_SRA),
        .result (shift_result)
    );

    always_comb begin
        result_next = '0;
        case (sel)
            ALU_ADD,
            ALU_SUB:  result_next = adder_sum;
            ALU_XOR:  result_next = A ^ B;
            ALU_OR:   result_next = A | B;
            ALU_AND:  result_next = A & B;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_next = shift_result;
            ALU_SLT:  result_next = {{(XLEN-1){1'b0}}, lt_signed_next};
            ALU_SLTU: result_next = {{(XLEN-1){1'b0}}, lt_unsigned_next};
            default:  result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out     <= '0;
            zero        <= 1'b1;
            lt_signed   <= 1'b0;
            lt_unsigned <= 1'b0;
        end else begin
            alu_out     <= result_next;
            zero        <= (result_next == '0);
            lt_signed   <= lt_signed_next;
            lt_unsigned <= lt_unsigned_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: each driven operation queues its expected outputs,
// which are popped and compared one clock later.
module tb_alu;

    typedef struct packed {
        logic [31:0] out;
        logic        z;
        logic        lts;
        logic        ltu;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] B   = '0;
    logic [3:0]  sel = '0;
    logic [31:0] alu_out;
    logic        zero;
    logic        lt_signed;
    logic        lt_unsigned;

    exp_t  sb[$];
    string tag_q[$];
    int    checks = 0;
    int    passes = 0;

    alu dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .sel         (sel),
        .alu_out     (alu_out),
        .zero        (zero),
        .lt_signed   (lt_signed),
        .lt_unsigned (lt_unsigned)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [31:0] o, logic z, logic s, logic u);
        exp_t e;
        e.out = o;
        e.z   = z;
        e.lts = s;
        e.ltu = u;
        return e;
    endfunction

    // Behavioural reference used for the randomised back-to-back stream
    function automatic exp_t model(logic r, logic [3:0] s, logic [31:0] a, logic [31:0] b);
        logic [31:0] res;
        if (r) return mk(32'h0, 1'b1, 1'b0, 1'b0);
        case (s)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a ^ b;
            4'd3:    res = a | b;
            4'd4:    res = a & b;
            4'd5:    res = a << b[4:0];
            4'd6:    res = a >> b[4:0];
            4'd7:    res = $signed(a) >>> b[4:0];
            4'd8:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    res = (a < b) ? 32'd1 : 32'd0;
            default: res = 32'h0;
        endcase
        return mk(res, res == 32'h0, $signed(a) < $signed(b), a < b);
    endfunction

    task automatic checkOutput();
        exp_t  e;
        string t;
        checks++;
        assert (sb.size() > 0) passes++;
        else $error("[TB] FAIL scoreboard_empty: observed size %0d required >0", sb.size());
        if (sb.size() == 0) return;
        e = sb.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (alu_out === e.out) passes++;
        else $error("[TB] FAIL %s.alu_out: observed %h required %h", t, alu_out, e.out);
        checks++;
        assert (zero === e.z) passes++;
        else $error("[TB] FAIL %s.zero: observed %b required %b", t, zero, e.z);
        checks++;
        assert (lt_signed === e.lts) passes++;
        else $error("[TB] FAIL %s.lt_signed: observed %b required %b", t, lt_signed, e.lts);
        checks++;
        assert (lt_unsigned === e.ltu) passes++;
        else $error("[TB] FAIL %s.lt_unsigned: observed %b required %b", t, lt_unsigned, e.ltu);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] s, input logic [31:0] a,
                                 input logic [31:0] b, input exp_t e, input string t);
        rst = r;
        sel = s;
        A   = a;
        B   = b;
        sb.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic        r;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] b;

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'd0, 32'd10, 32'd20, mk(32'h0, 1, 0, 0), "reset0");
        applyStimulus(1'b1, 4'd0, 32'd10, 32'd20, mk(32'h0, 1, 0, 0), "reset1");

        applyStimulus(0, 4'b0000, 32'd10,         32'd20,         mk(32'd30,         0, 1, 1), "add");
        applyStimulus(0, 4'b0000, 32'h7FFFFFFF,   32'd1,          mk(32'h80000000,   0, 0, 0), "add_wrap");
        applyStimulus(0, 4'b0001, 32'd20,         32'd10,         mk(32'd10,         0, 0, 0), "sub");
        applyStimulus(0, 4'b0001, 32'h80000000,   32'd1,          mk(32'h7FFFFFFF,   0, 1, 0), "sub_min");
        applyStimulus(0, 4'b0001, 32'd5,          32'd5,          mk(32'h0,          1, 0, 0), "sub_eq");
        applyStimulus(0, 4'b0010, 32'hF0F0F0F0,   32'h0F0F0F0F,   mk(32'hFFFFFFFF,   0, 1, 0), "xor");
        applyStimulus(0, 4'b0011, 32'h12340000,   32'h00005678,   mk(32'h12345678,   0, 0, 0), "or");
        applyStimulus(0, 4'b0100, 32'hFFFF0000,   32'h00FF00FF,   mk(32'h00FF0000,   0, 1, 0), "and");
        applyStimulus(0, 4'b0101, 32'd1,          32'd8,          mk(32'h00000100,   0, 1, 1), "sll");
        applyStimulus(0, 4'b0110, 32'h80000000,   32'd4,          mk(32'h08000000,   0, 1, 0), "srl");
        applyStimulus(0, 4'b0111, 32'h80000000,   32'd4,          mk(32'hF8000000,   0, 1, 0), "sra");
        applyStimulus(0, 4'b0101, 32'd1,          32'h28,         mk(32'h00000100,   0, 1, 1), "sll_b5");
        applyStimulus(0, 4'b0111, 32'h80000000,   32'd31,         mk(32'hFFFFFFFF,   0, 1, 0), "sra31");
        applyStimulus(0, 4'b0111, 32'h70000000,   32'd31,         mk(32'h0,          1, 0, 0), "sra31_pos");
        applyStimulus(0, 4'b0101, 32'h3,          32'd31,         mk(32'h80000000,   0, 1, 1), "sll31");
        applyStimulus(0, 4'b0110, 32'hFFFFFFFF,   32'd0,          mk(32'hFFFFFFFF,   0, 1, 0), "srl0");
        applyStimulus(0, 4'b1000, 32'hFFFFFFFB,   32'd10,         mk(32'd1,          0, 1, 0), "slt");
        applyStimulus(0, 4'b1001, 32'hFFFFFFFF,   32'd1,          mk(32'h0,          1, 1, 0), "sltu");
        applyStimulus(0, 4'b1001, 32'd1,          32'hFFFFFFFF,   mk(32'd1,          0, 0, 1), "sltu_true");
        applyStimulus(0, 4'b1111, 32'd3,          32'd4,          mk(32'h0,          1, 1, 1), "sel_f");
        applyStimulus(0, 4'b1010, 32'd7,          32'd7,          mk(32'h0,          1, 0, 0), "sel_a");

        // Back-to-back randomised stream with reset asserted mid-stream
        for (int i = 0; i < 40; i++) begin
            r = (i == 20 || i == 21);
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            applyStimulus(r, s, a, b, model(r, s, a, b), $sformatf("stream%0d", i));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
